// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: one shared add/shift datapath drives y to zero
// over `iters` cycles and reports the gain-scaled magnitude and atan2(y, x).
module cordic_vectoring_iter #(
  parameter int m           = 6,
  parameter int n           = 10,
  parameter int iter_length = 4,
  parameter int iters       = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [m+n-1:0]       x_in,
  input  logic [m+n-1:0]       y_in,
  output logic                 busy,
  output logic                 done,
  output logic [m+n+1:0]       mag_out,
  output logic [m+n-1:0]       angle_out
);

  localparam int W  = m + n;
  localparam int XW = W + 2;
  localparam logic [iter_length-1:0] LAST    = iter_length'(iters - 1);
  localparam logic signed [W-1:0]    HALF_PI = W'(1608);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t state, state_nx;

  logic signed [XW-1:0]   x_r, y_r, x_nx, y_nx, x_sh, y_sh;
  logic signed [XW-1:0]   x_ext, y_ext, x_pre, y_pre;
  logic signed [W-1:0]    z_r, z_nx, z_pre, atan_i;
  logic [iter_length-1:0] i_r;

  // Q6.10 arctangent of 2^-k, rounded to nearest; zero once below one LSB.
  function automatic logic signed [W-1:0] atan_rom(input logic [iter_length-1:0] k);
    case (int'(k))
      0:       atan_rom = W'(804);
      1:       atan_rom = W'(475);
      2:       atan_rom = W'(251);
      3:       atan_rom = W'(127);
      4:       atan_rom = W'(64);
      5:       atan_rom = W'(32);
      6:       atan_rom = W'(16);
      7:       atan_rom = W'(8);
      8:       atan_rom = W'(4);
      9:       atan_rom = W'(2);
      10:      atan_rom = W'(1);
      default: atan_rom = '0;
    endcase
  endfunction

  assign x_ext  = {{2{x_in[W-1]}}, x_in};
  assign y_ext  = {{2{y_in[W-1]}}, y_in};
  assign atan_i = atan_rom(i_r);
  assign x_sh   = x_r >>> i_r;
  assign y_sh   = y_r >>> i_r;

  // Fold left-half-plane inputs by +/-90 degrees; negation is done at the
  // guarded width so the most negative input does not wrap.
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_in[W-1]) begin
      if (!y_in[W-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = HALF_PI;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -HALF_PI;
      end
    end
  end

  always_comb begin
    if (!y_r[XW-1]) begin
      x_nx = x_r + y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + atan_i;
    end else begin
      x_nx = x_r - y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - atan_i;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ITER;
      S_ITER:  if (i_r == LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      i_r       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mag_out   <= '0;
      angle_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_r  <= x_pre;
            y_r  <= y_pre;
            z_r  <= z_pre;
            i_r  <= '0;
            busy <= 1'b1;
          end
        end
        S_ITER: begin
          x_r <= x_nx;
          y_r <= y_nx;
          z_r <= z_nx;
          i_r <= i_r + 1'b1;
          if (i_r == LAST) begin
            mag_out   <= x_nx;
            angle_out <= z_nx;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        S_DONE: done <= 1'b0;
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Directed bench for cordic_vectoring_iter: hand-computed magnitudes/angles with
// tolerances, handshake timing, start-ignore, asynchronous reset and extremes.
module tb_cordic_vectoring_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x_in, y_in;
  logic        busy, done;
  logic [17:0] mag_out;
  logic [15:0] angle_out;

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;
  int bcnt;
  int dp0;

  cordic_vectoring_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp, input int tol);
    n_checks++;
    assert ((((act - exp) <= tol) && ((exp - act) <= tol)) === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, act, exp, tol);
    end
  endtask

  // Launch one operation and wait (bounded) for done; bc = cycles busy was seen high.
  task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, output int bc);
    @(negedge clk);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    for (int k = 0; k < 40 && done !== 1'b1; k++) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'b0, busy}, 0, 0);
    check("rst_done",  {31'b0, done}, 0, 0);
    check("rst_mag",   $signed(mag_out), 0, 0);
    check("rst_angle", $signed(angle_out), 0, 0);
    rst = 1'b0;

    // (1024, 0): angle 0, magnitude K*1024
    run_op(16'sd1024, 16'sd0, bcnt);
    check("t1_done",      {31'b0, done}, 1, 0);
    check("t1_busy_cyc",  bcnt, 12, 0);
    check("t1_busy_low",  {31'b0, busy}, 0, 0);
    check("t1_mag",       $signed(mag_out), 1686, 4);
    check("t1_angle",     $signed(angle_out), 0, 3);
    @(negedge clk);
    check("t1_done_pulse", {31'b0, done}, 0, 0);

    run_op(16'sd1024, 16'sd1024, bcnt);
    check("t2a_mag",   $signed(mag_out), 2385, 4);
    check("t2a_angle", $signed(angle_out), 804, 3);
    run_op(16'sd0, -16'sd1024, bcnt);
    check("t2b_mag",   $signed(mag_out), 1686, 4);
    check("t2b_angle", $signed(angle_out), -1608, 3);

    // Left half-plane inputs exercise the pre-rotation
    run_op(-16'sd1024, 16'sd0, bcnt);
    check("t3a_mag",   $signed(mag_out), 1686, 4);
    check("t3a_angle", $signed(angle_out), 3217, 3);
    run_op(-16'sd1024, -16'sd1024, bcnt);
    check("t3b_mag",   $signed(mag_out), 2385, 4);
    check("t3b_angle", $signed(angle_out), -2413, 3);

    // Outputs hold while idle even as inputs change
    x_in = 16'sd77;
    y_in = -16'sd300;
    repeat (4) @(negedge clk);
    check("hold_mag",   $signed(mag_out), 2385, 4);
    check("hold_angle", $signed(angle_out), -2413, 3);

    // Most negative corner: guard bits must absorb the growth
    run_op(16'h8000, 16'h8000, bcnt);
    check("t6_mag",   $signed(mag_out), 76317, 16);
    check("t6_angle", $signed(angle_out), -2413, 3);

    run_op(16'sd0, 16'sd0, bcnt);
    check("zero_mag",   $signed(mag_out), 0, 0);
    check("zero_angle", $signed(angle_out), 0, 3217);

    // start held high with operands changing mid-operation
    #1 dp0 = done_pulses;
    @(negedge clk);
    x_in  = 16'sd1024;
    y_in  = 16'sd0;
    start = 1'b1;
    @(negedge clk);
    x_in = 16'sd1024;
    y_in = 16'sd1024;
    for (int k = 0; k < 40 && done !== 1'b1; k++) @(negedge clk);
    check("t4_done1",  {31'b0, done}, 1, 0);
    check("t4_mag1",   $signed(mag_out), 1686, 4);
    check("t4_angle1", $signed(angle_out), 0, 3);
    @(negedge clk);
    check("t4_idle_busy", {31'b0, busy}, 0, 0);
    @(negedge clk);
    check("t4_accept2", {31'b0, busy}, 1, 0);
    start = 1'b0;
    for (int k = 0; k < 40 && done !== 1'b1; k++) @(negedge clk);
    check("t4_done2",  {31'b0, done}, 1, 0);
    check("t4_mag2",   $signed(mag_out), 2385, 4);
    check("t4_angle2", $signed(angle_out), 804, 3);
    repeat (20) @(negedge clk);
    #1 check("t4_pulses", done_pulses - dp0, 2, 0);

    // Asynchronous reset during the 5th iteration cycle
    @(negedge clk);
    x_in  = 16'sd1024;
    y_in  = 16'sd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy",  {31'b0, busy}, 0, 0);
    check("t5_done",  {31'b0, done}, 0, 0);
    check("t5_mag",   $signed(mag_out), 0, 0);
    check("t5_angle", $signed(angle_out), 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle", {31'b0, busy}, 0, 0);
    run_op(-16'sd1024, -16'sd1024, bcnt);
    check("t5_done_after", {31'b0, done}, 1, 0);
    check("t5_busy_cyc",   bcnt, 12, 0);
    check("t5_mag_after",  $signed(mag_out), 2385, 4);
    check("t5_angle_after", $signed(angle_out), -2413, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
